data_stream_fsm: RTL and testbench

Parametrised sequencer that fetches characters from a data source and hands each one to the transmitter, one at a time, until a configurable character limit is reached or the source reports no more data. It sits between the message/data buffer (`newData`/`noMore`/`wantData`) and the serial send path (`startSend`/`sendDone`). It adds the following:
- a parametrised limit
- an exposed character count
- a synchronous abort
- an optional send-timeout watchdog

---
 rtl/data_fsm_pkg.sv | 19 +
 rtl/send_watchdog.sv | 39 +++
 rtl/data_stream_fsm.sv | 137 +++++++++++++
 tb/tb_data_stream_fsm.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/data_fsm_pkg.sv
// Shared types and default constants for the data stream sequencer.
// Optional feature macro used by the RTL: DATA_FSM_TIMEOUT_EN (send-timeout watchdog).
package data_fsm_pkg;

    localparam int unsigned DEFAULT_MAX_CHARS      = 198;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 1024;

    // TMO is only reachable when the watchdog is built in.
    typedef enum logic [2:0] {
        IDLE,
        ASK,
        SEND,
        WAITSEND,
        FULL,
        NODATA,
        TMO
    } state_t;

endpackage

// File: rtl/send_watchdog.sv
// Cycle counter that flags expiry after TIMEOUT_CYCLES enabled cycles.
// Only instantiated when DATA_FSM_TIMEOUT_EN is defined.
module send_watchdog
    import data_fsm_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    // Counter only needs to reach TIMEOUT_CYCLES-1: the first enabled cycle sees 0.
    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] r_count;

    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("send_watchdog: TIMEOUT_CYCLES must be at least 1");
    end

    // Expiry is seen during the last allowed cycle so the caller can still let sendDone win.
    assign expired = enable && (r_count == LAST);

    // Count enabled cycles, saturating at the last one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && (r_count != LAST)) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/data_stream_fsm.sv
// Sequencer fetching characters from a data source and handing each to the transmitter
// until MAX_CHARS have been sent or the source runs dry.
// Optional feature: define DATA_FSM_TIMEOUT_EN to add the send-timeout watchdog (TMO state).
module data_stream_fsm
    import data_fsm_pkg::*;
#(
    parameter int unsigned MAX_CHARS      = DEFAULT_MAX_CHARS,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic                             abort,
    input  logic                             newData,
    input  logic                             noMore,
    input  logic                             sendDone,
    output logic                             wantData,
    output logic                             startSend,
    output logic                             done,
    output logic                             noMoreDone,
    output logic                             timedOut,
    output logic                             busy,
    output logic [$clog2(MAX_CHARS+1)-1:0]   charCount
);

    localparam int unsigned CW = $clog2(MAX_CHARS + 1);
    localparam logic [CW-1:0] LIMIT = CW'(MAX_CHARS);

    if ((MAX_CHARS < 1) || (MAX_CHARS > 65535)) begin : g_bad_limit
        $error("data_stream_fsm: MAX_CHARS must be in 1..65535");
    end
    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("data_stream_fsm: TIMEOUT_CYCLES must be at least 1");
    end

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_count;
    logic          r_want;
    logic          r_send;
    logic          r_done;
    logic          r_nomore;
    logic          r_busy;
    logic          w_expired;

`ifdef DATA_FSM_TIMEOUT_EN
    logic r_tmo;

    send_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (r_state == SEND),
        .enable  (r_state == WAITSEND),
        .expired (w_expired)
    );

    assign timedOut = r_tmo;
`else
    assign w_expired = 1'b0;
    assign timedOut  = 1'b0;
`endif

    // Next-state decode; abort overrides every other transition.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:     if (start) w_next = ASK;
            ASK: begin
                if (noMore) begin
                    w_next = NODATA;
                end else if (newData) begin
                    w_next = SEND;
                end
            end
            SEND:     w_next = WAITSEND;
            WAITSEND: begin
                if (sendDone) begin
                    w_next = (r_count == LIMIT) ? FULL : ASK;
                end else if (w_expired) begin
                    w_next = TMO;
                end
            end
            FULL:     w_next = IDLE;
            NODATA:   w_next = IDLE;
            TMO:      w_next = IDLE;
            default:  w_next = IDLE;
        endcase
        if (abort) begin
            w_next = IDLE;
        end
    end

    // State, registered Moore outputs and the character counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_count  <= '0;
            r_want   <= 1'b0;
            r_send   <= 1'b0;
            r_done   <= 1'b0;
            r_nomore <= 1'b0;
            r_busy   <= 1'b0;
`ifdef DATA_FSM_TIMEOUT_EN
            r_tmo    <= 1'b0;
`endif
        end else begin
            r_state  <= w_next;
            // Outputs are decoded from the next state so they align with the state register.
            r_want   <= (w_next == ASK);
            r_send   <= (w_next == SEND);
            r_done   <= (w_next == FULL);
            r_nomore <= (w_next == NODATA);
            r_busy   <= (w_next != IDLE);
`ifdef DATA_FSM_TIMEOUT_EN
            r_tmo    <= (w_next == TMO);
`endif
            // Abort freezes the count so the partial progress stays visible.
            if (!abort) begin
                if ((r_state == IDLE) && start) begin
                    r_count <= '0;
                end else if ((r_state == SEND) && (r_count != LIMIT)) begin
                    r_count <= r_count + 1'b1;
                end
            end
        end
    end

    assign wantData   = r_want;
    assign startSend  = r_send;
    assign done       = r_done;
    assign noMoreDone = r_nomore;
    assign busy       = r_busy;
    assign charCount  = r_count;

endmodule

// File: tb/tb_data_stream_fsm.sv
// Directed bench for data_stream_fsm: one instance with MAX_CHARS=4 / TIMEOUT_CYCLES=8
// and one with default parameters, sharing the same stimulus.
module tb_data_stream_fsm;

    logic clk;
    logic reset;
    logic start;
    logic abort;
    logic newData;
    logic noMore;
    logic sendDone;

    logic       d4_want, d4_send, d4_done, d4_nomore, d4_tmo, d4_busy;
    logic [2:0] d4_count;
    logic       db_want, db_send, db_done, db_nomore, db_tmo, db_busy;
    logic [7:0] db_count;

    int n_checks;
    int n_errors;

    data_stream_fsm #(
        .MAX_CHARS      (4),
        .TIMEOUT_CYCLES (8)
    ) u_dut4 (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .newData    (newData),
        .noMore     (noMore),
        .sendDone   (sendDone),
        .wantData   (d4_want),
        .startSend  (d4_send),
        .done       (d4_done),
        .noMoreDone (d4_nomore),
        .timedOut   (d4_tmo),
        .busy       (d4_busy),
        .charCount  (d4_count)
    );

    data_stream_fsm u_dut198 (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .newData    (newData),
        .noMore     (noMore),
        .sendDone   (sendDone),
        .wantData   (db_want),
        .startSend  (db_send),
        .done       (db_done),
        .noMoreDone (db_nomore),
        .timedOut   (db_tmo),
        .busy       (db_busy),
        .charCount  (db_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    int edges;
    int pulses;
    bit seen;

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        newData  = 1'b0;
        noMore   = 1'b0;
        sendDone = 1'b0;
        #2;

        // Reset values
        do_reset();
        tick();
        tick();
        check("rst_want", d4_want, 0);
        check("rst_send", d4_send, 0);
        check("rst_done", d4_done, 0);
        check("rst_nomore", d4_nomore, 0);
        check("rst_tmo", d4_tmo, 0);
        check("rst_busy", d4_busy, 0);
        check("rst_count", d4_count, 0);
        check("rst_count198", db_count, 0);

        // noMore has priority over newData
        pulse_start();
        check("nd_want", d4_want, 1);
        check("nd_busy", d4_busy, 1);
        noMore  = 1'b1;
        newData = 1'b1;
        tick();
        check("nd_nomoredone", d4_nomore, 1);
        check("nd_nosend", d4_send, 0);
        noMore  = 1'b0;
        newData = 1'b0;
        tick();
        check("nd_pulse_end", d4_nomore, 0);
        check("nd_idle", d4_busy, 0);
        check("nd_count", d4_count, 0);

        // Full run MAX_CHARS=4 with handshakes held high
        do_reset();
        newData  = 1'b1;
        sendDone = 1'b1;
        pulse_start();
        edges  = 0;
        pulses = 0;
        seen   = 1'b0;
        while (!seen && edges < 100) begin
            tick();
            edges++;
            if (d4_send) pulses++;
            if (d4_done) seen = 1'b1;
        end
        check("f4_seen", seen, 1);
        check("f4_edges", edges, 12);
        check("f4_pulses", pulses, 4);
        check("f4_count", d4_count, 4);
        tick();
        check("f4_done_pulse", d4_done, 0);
        check("f4_idle", d4_busy, 0);
        check("f4_count_hold", d4_count, 4);

        // Full default run (198 chars)
        do_reset();
        pulse_start();
        edges = 0;
        seen  = 1'b0;
        while (!seen && edges < 700) begin
            tick();
            edges++;
            if (db_done) seen = 1'b1;
        end
        check("f198_seen", seen, 1);
        check("f198_edges", edges, 594);
        check("f198_count", db_count, 198);
        tick();
        check("f198_idle", db_busy, 0);
        pulse_start();
        check("f198_restart_count", db_count, 0);
        check("f198_restart_want", db_want, 1);

        // Abort in WAITSEND after 3 characters, with sendDone still high
        do_reset();
        pulse_start();
        for (int i = 0; i < 8; i++) tick();
        check("ab_ws_count", d4_count, 3);
        check("ab_ws_busy", d4_busy, 1);
        check("ab_ws_nosend", d4_send, 0);
        abort = 1'b1;
        tick();
        abort    = 1'b0;
        newData  = 1'b0;
        sendDone = 1'b0;
        check("ab_idle", d4_busy, 0);
        check("ab_count", d4_count, 3);
        check("ab_want", d4_want, 0);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (d4_done || d4_nomore || d4_busy) pulses++;
        end
        check("ab_quiet", pulses, 0);
        check("ab_count_hold", d4_count, 3);

        // Asynchronous reset mid-WAITSEND
        newData = 1'b1;
        pulse_start();
        tick();
        tick();
        check("ar_ws_busy", d4_busy, 1);
        check("ar_ws_count", d4_count, 1);
        reset = 1'b1;
        #1;
        check("ar_busy", d4_busy, 0);
        check("ar_count", d4_count, 0);
        reset = 1'b0;
        tick();
        tick();
        check("ar_stays_idle", d4_busy, 0);

`ifdef DATA_FSM_TIMEOUT_EN
        // Timeout with no sendDone: WAITSEND cycles end at edges 3..10
        do_reset();
        newData  = 1'b1;
        sendDone = 1'b0;
        pulse_start();
        for (int i = 0; i < 9; i++) tick();
        check("to_not_yet", d4_tmo, 0);
        check("to_ws_busy", d4_busy, 1);
        tick();
        check("to_timedout", d4_tmo, 1);
        tick();
        check("to_pulse_end", d4_tmo, 0);
        check("to_idle", d4_busy, 0);

        // sendDone on the 8th WAITSEND cycle beats the timeout
        do_reset();
        pulse_start();
        for (int i = 0; i < 9; i++) tick();
        sendDone = 1'b1;
        tick();
        sendDone = 1'b0;
        check("tw_no_tmo", d4_tmo, 0);
        check("tw_ask", d4_want, 1);
`else
        // Without the watchdog WAITSEND waits indefinitely
        do_reset();
        newData  = 1'b1;
        sendDone = 1'b0;
        pulse_start();
        for (int i = 0; i < 20; i++) tick();
        check("nt_tmo", d4_tmo, 0);
        check("nt_busy", d4_busy, 1);
        check("nt_count", d4_count, 1);
`endif
        newData = 1'b0;
        abort   = 1'b1;
        tick();
        abort = 1'b0;
        check("end_idle", d4_busy, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
